// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
// Shared types and constants for the CPU memory-bus arbiter:
//   arb_state_e  - arbiter FSM state (IDLE, BUSY)
//   PORT_D/I     - port identifiers (data = 0, fetch = 1)
//   DEF_*        - default watchdog limit and error read data
//   bus_cmd_t    - one bus command {address, write, wstrb, wdata}
package cpu_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEADDEAD;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/cpu_arb_slot.sv
// cpu_arb_slot
// Capture slot for one requester port: a pending flag plus the command that
// came with the request pulse. The slot is cleared when the arbiter grants it.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   request_i      - accepted request pulse (already filtered for violations)
//   cmd_i          - command presented with the request
//   grant_i        - arbiter takes this slot's command this cycle
//   pending_o      - a captured command is waiting (registered)
//   cmd_o          - the captured command
module cpu_arb_slot
  import cpu_bus_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     request_i,
  input  bus_cmd_t cmd_i,
  input  logic     grant_i,
  output logic     pending_o,
  output bus_cmd_t cmd_o
);

  logic     pending_q, pending_d;
  bus_cmd_t cmd_q, cmd_d;

  // A request granted in its own arrival cycle bypasses the slot, so grant
  // takes precedence and the slot stays empty.
  always_comb begin
    pending_d = pending_q;
    cmd_d     = cmd_q;
    if (request_i) begin
      pending_d = 1'b1;
      cmd_d     = cmd_i;
    end
    if (grant_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
    end
  end

  assign pending_o = pending_q;
  assign cmd_o     = cmd_q;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Shares one memory bus between the CPU data port (d_*) and the instruction
// fetch port (i_*). Requests are single-cycle pulses captured in per-port
// slots; one transaction is outstanding on the bus at a time; the ack and
// read data are routed combinationally back to the owning port; a watchdog
// terminates transactions that never receive mem_ack.
//
// Handshake: every *_request and *_ack is a one-cycle pulse. A command is
// valid only in its request cycle. A port may have one request outstanding;
// extra pulses while pending or in flight are dropped. mem_* command fields
// are registered and held from mem_request until mem_ack or timeout.
//
// Build option: define CPU_ARB_RR_EN for round-robin arbitration on ties;
// otherwise data strictly beats fetch.
//
// Parameters: TIMEOUT_CYCLES (1..65535), ERR_RDATA
// Ports:
//   clock, reset_n                      - clock, async active-low reset
//   d_request/address/write/wstrb/wdata - data-port command
//   d_rdata, d_ack                      - data-port response
//   i_request/address                   - fetch command (read only)
//   i_rdata, i_ack                      - fetch response
//   mem_request/address/write/wstrb/wdata - bus command
//   mem_rdata, mem_ack                  - bus response
//   bus_error, bus_error_addr           - watchdog report
//   dbg_state_o                         - current FSM state
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        d_request,
  input  logic [31:0] d_address,
  input  logic        d_write,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  input  logic        i_request,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic [31:0] bus_error_addr,
  output arb_state_e  dbg_state_o
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  bus_cmd_t    mem_cmd_q, mem_cmd_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [31:0] err_addr_q, err_addr_d;
`ifdef CPU_ARB_RR_EN
  logic        last_q, last_d;
`endif

  logic     busy, timeout, done, can_issue;
  logic     d_pending, i_pending;
  logic     d_accept, i_accept;
  logic     d_avail, i_avail;
  logic     d_grant, i_grant;
  logic     winner;
  bus_cmd_t d_cmd_in, i_cmd_in, d_slot_cmd, i_slot_cmd, d_cmd_eff, i_cmd_eff;
  logic [31:0] ack_rdata;

  assign busy    = (state_q == BUSY);
  // A mem_ack in the timeout cycle wins over the watchdog.
  assign timeout = busy && (wd_cnt_q == 16'(TIMEOUT_CYCLES));
  assign done    = busy && (mem_ack || timeout);
  assign can_issue = !busy || done;

  assign d_cmd_in = '{address: d_address, write: d_write, wstrb: d_wstrb, wdata: d_wdata};
  assign i_cmd_in = '{address: i_address, write: 1'b0, wstrb: 4'b0, wdata: 32'b0};

  // A port is occupied while its slot is pending or its transaction is on
  // the bus; in the completion cycle the port is free again, so a request
  // arriving alongside its own ack is accepted.
  assign d_accept = d_request && !d_pending && !(busy && owner_q == PORT_D && !done);
  assign i_accept = i_request && !i_pending && !(busy && owner_q == PORT_I && !done);

  // Fresh requests are visible to arbitration in their own cycle so an idle
  // bus issues on the very next cycle.
  assign d_avail   = d_pending || d_accept;
  assign i_avail   = i_pending || i_accept;
  assign d_cmd_eff = d_pending ? d_slot_cmd : d_cmd_in;
  assign i_cmd_eff = i_pending ? i_slot_cmd : i_cmd_in;

  always_comb begin
    winner = PORT_D;
    if (d_avail && i_avail) begin
`ifdef CPU_ARB_RR_EN
      winner = (last_q == PORT_D) ? PORT_I : PORT_D;
`else
      winner = PORT_D;
`endif
    end else if (i_avail) begin
      winner = PORT_I;
    end
  end

  assign d_grant = can_issue && d_avail && (winner == PORT_D);
  assign i_grant = can_issue && i_avail && (winner == PORT_I);

  cpu_arb_slot u_slot_d (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .request_i (d_accept),
    .cmd_i     (d_cmd_in),
    .grant_i   (d_grant),
    .pending_o (d_pending),
    .cmd_o     (d_slot_cmd)
  );

  cpu_arb_slot u_slot_i (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .request_i (i_accept),
    .cmd_i     (i_cmd_in),
    .grant_i   (i_grant),
    .pending_o (i_pending),
    .cmd_o     (i_slot_cmd)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mem_cmd_d  = mem_cmd_q;
    mem_req_d  = 1'b0;
    wd_cnt_d   = wd_cnt_q;
    err_addr_d = err_addr_q;
`ifdef CPU_ARB_RR_EN
    last_d     = last_q;
`endif

    if (busy && !done) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
    if (timeout && !mem_ack) begin
      err_addr_d = mem_cmd_q.address;
    end

    if (can_issue) begin
      if (d_avail || i_avail) begin
        state_d   = BUSY;
        owner_d   = winner;
        mem_cmd_d = (winner == PORT_D) ? d_cmd_eff : i_cmd_eff;
        mem_req_d = 1'b1;
        wd_cnt_d  = 16'd0;
`ifdef CPU_ARB_RR_EN
        last_d    = winner;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= PORT_D;
      mem_cmd_q  <= '0;
      mem_req_q  <= 1'b0;
      wd_cnt_q   <= 16'd0;
      err_addr_q <= 32'b0;
`ifdef CPU_ARB_RR_EN
      last_q     <= PORT_I;  // data wins the first tie
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mem_cmd_q  <= mem_cmd_d;
      mem_req_q  <= mem_req_d;
      wd_cnt_q   <= wd_cnt_d;
      err_addr_q <= err_addr_d;
`ifdef CPU_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign ack_rdata = mem_ack ? mem_rdata : ERR_RDATA;

  assign d_ack   = done && (owner_q == PORT_D);
  assign i_ack   = done && (owner_q == PORT_I);
  assign d_rdata = d_ack ? ack_rdata : 32'b0;
  assign i_rdata = i_ack ? ack_rdata : 32'b0;

  assign mem_request = mem_req_q;
  assign mem_address = mem_cmd_q.address;
  assign mem_write   = mem_cmd_q.write;
  assign mem_wstrb   = mem_cmd_q.wstrb;
  assign mem_wdata   = mem_cmd_q.wdata;

  assign bus_error      = timeout && !mem_ack;
  assign bus_error_addr = err_addr_q;
  assign dbg_state_o    = state_q;

endmodule
